// File: rtl/lcd_nibble_seq_if.sv
// Byte-write handshake between a host and the 4-bit LCD sequencer.
// The host drives a byte and its register select; the sequencer accepts it
// on a cycle where both wr_valid and wr_ready are high.
interface lcd_nibble_seq_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_rs, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_rs, input  wr_data, output wr_ready);
endinterface

// File: rtl/lcd_nibble_seq.sv
// HD44780-style 4-bit LCD sequencer.
// After reset it runs the power-on nibble sequence 3,3,3,2 with programmable
// waits, then accepts bytes over the wr handshake and emits each as high
// nibble then low nibble, each with its own enable pulse and settle time.
// Optional build macro: LCD_CLEAR_WAIT_EN -- when defined, command bytes
// 0x01..0x03 (clear/home) settle for CLR_WAIT instead of CMD_WAIT.
module lcd_nibble_seq #(
    parameter int POWER_WAIT = 750000,
    parameter int INIT_WAIT1 = 205000,
    parameter int INIT_WAIT2 = 5000,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 82000,
    parameter int E_CYCLES   = 12,
    parameter int SETUP      = 2,
    parameter int NIB_GAP    = 50,
    parameter int CNT_W      = 20
) (
    input  logic                clk,
    input  logic                reset,
    lcd_nibble_seq_if.slave     wr,
    output logic                init_done,
    output logic [3:0]          lcd_d,
    output logic                lcd_rs,
    output logic                lcd_e
);

    typedef enum logic [4:0] {
        S_RST, S_PWR,
        S_E1, S_G1, S_E2, S_G2, S_E3, S_G3, S_E4, S_G4,
        S_IDLE,
        S_SH, S_EH, S_NG, S_SL, S_EL, S_WT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             init_done_q, init_done_d;
    logic [3:0]       lcd_d_q, lcd_d_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic             wr_ready_q, wr_ready_d;

    // Scratch values used only inside the next-state logic.
    logic [CNT_W-1:0] dur;
    state_e           nxt;
    logic             timed;
    logic             clr_byte;

    assign init_done   = init_done_q;
    assign lcd_d       = lcd_d_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_e       = lcd_e_q;
    assign wr.wr_ready = wr_ready_q;

    // Next state, per-state dwell counter, byte latch, and the output values
    // that the next state will present (so every output comes from a flop).
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        rs_d        = rs_q;
        data_d      = data_q;
        dur         = '0;
        nxt         = S_RST;
        timed       = 1'b1;

`ifdef LCD_CLEAR_WAIT_EN
        clr_byte = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
`else
        clr_byte = 1'b0;
`endif

        case (state_q)
            S_RST:  begin timed = 1'b0; state_d = S_PWR; cnt_d = '0; end
            S_PWR:  begin dur = CNT_W'(POWER_WAIT); nxt = S_E1;   end
            S_E1:   begin dur = CNT_W'(E_CYCLES);   nxt = S_G1;   end
            S_G1:   begin dur = CNT_W'(INIT_WAIT1); nxt = S_E2;   end
            S_E2:   begin dur = CNT_W'(E_CYCLES);   nxt = S_G2;   end
            S_G2:   begin dur = CNT_W'(INIT_WAIT2); nxt = S_E3;   end
            S_E3:   begin dur = CNT_W'(E_CYCLES);   nxt = S_G3;   end
            S_G3:   begin dur = CNT_W'(CMD_WAIT);   nxt = S_E4;   end
            S_E4:   begin dur = CNT_W'(E_CYCLES);   nxt = S_G4;   end
            S_G4:   begin dur = CNT_W'(CMD_WAIT);   nxt = S_IDLE; end
            S_IDLE: begin
                timed = 1'b0;
                cnt_d = '0;
                if (wr.wr_valid && wr_ready_q) begin
                    state_d = S_SH;
                    rs_d    = wr.wr_rs;
                    data_d  = wr.wr_data;
                end
            end
            S_SH:   begin dur = CNT_W'(SETUP);      nxt = S_EH;   end
            S_EH:   begin dur = CNT_W'(E_CYCLES);   nxt = S_NG;   end
            S_NG:   begin dur = CNT_W'(NIB_GAP);    nxt = S_SL;   end
            S_SL:   begin dur = CNT_W'(SETUP);      nxt = S_EL;   end
            S_EL:   begin dur = CNT_W'(E_CYCLES);   nxt = S_WT;   end
            S_WT:   begin
                dur = clr_byte ? CNT_W'(CLR_WAIT) : CNT_W'(CMD_WAIT);
                nxt = S_IDLE;
            end
            default: begin timed = 1'b0; state_d = S_RST; cnt_d = '0; end
        endcase

        if (timed && cnt_q == dur - CNT_W'(1)) begin
            state_d = nxt;
            cnt_d   = '0;
        end

        init_done_d = init_done_q | (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_IDLE);
        lcd_e_d     = (state_d == S_E1) || (state_d == S_E2) || (state_d == S_E3) ||
                      (state_d == S_E4) || (state_d == S_EH) || (state_d == S_EL);
        lcd_rs_d    = (state_d == S_SH) || (state_d == S_EH) || (state_d == S_NG) ||
                      (state_d == S_SL) || (state_d == S_EL) || (state_d == S_WT) ? rs_d : 1'b0;

        case (state_d)
            S_PWR, S_E1, S_G1, S_E2, S_G2, S_E3: lcd_d_d = 4'h3;
            // The final init nibble is presented SETUP cycles before E4 rises.
            S_G3:                lcd_d_d = (cnt_d >= CNT_W'(CMD_WAIT - SETUP)) ? 4'h2 : 4'h3;
            S_E4, S_G4:          lcd_d_d = 4'h2;
            S_SH, S_EH, S_NG:    lcd_d_d = data_d[7:4];
            S_SL, S_EL, S_WT:    lcd_d_d = data_d[3:0];
            default:             lcd_d_d = 4'h0;
        endcase
    end

    // State, counter, byte latch and all outputs; synchronous reset restarts init.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
            lcd_d_q     <= 4'h0;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            lcd_d_q     <= lcd_d_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_seq.sv
// Self-checking bench for lcd_nibble_seq.
// A reference trace of expected per-cycle outputs is built from timed
// segments (init sequence, byte writes) and compared every cycle.
module tb_lcd_nibble_seq;

    localparam int PW   = 40;
    localparam int IW1  = 20;
    localparam int IW2  = 10;
    localparam int CW   = 8;
    localparam int CLRW = 30;
    localparam int EC   = 3;
    localparam int SU   = 2;
    localparam int NG   = 4;
    localparam int INIT_LEN = PW + 4*EC + IW1 + IW2 + 2*CW;

    typedef struct packed {
        logic       e;
        logic [3:0] d;
        logic       rs;
        logic       rdy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic [3:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_e;

    lcd_nibble_seq_if wr_if ();

    lcd_nibble_seq #(
        .POWER_WAIT(PW), .INIT_WAIT1(IW1), .INIT_WAIT2(IW2), .CMD_WAIT(CW),
        .CLR_WAIT(CLRW), .E_CYCLES(EC), .SETUP(SU), .NIB_GAP(NG), .CNT_W(20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_if),
        .init_done (init_done),
        .lcd_d     (lcd_d),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];
    obs_t exp_cur;
    logic mdl_rst;
    logic seen_ready;
    int   rel_cyc;

    task automatic push_seg(input int n, input logic e, input logic [3:0] d,
                            input logic rs, input logic rdy, input logic done);
        obs_t v;
        v = '{e: e, d: d, rs: rs, rdy: rdy, done: done};
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_init();
        push_seg(PW,      0, 4'h3, 0, 0, 0);
        push_seg(EC,      1, 4'h3, 0, 0, 0);
        push_seg(IW1,     0, 4'h3, 0, 0, 0);
        push_seg(EC,      1, 4'h3, 0, 0, 0);
        push_seg(IW2,     0, 4'h3, 0, 0, 0);
        push_seg(EC,      1, 4'h3, 0, 0, 0);
        push_seg(CW - SU, 0, 4'h3, 0, 0, 0);
        push_seg(SU,      0, 4'h2, 0, 0, 0);
        push_seg(EC,      1, 4'h2, 0, 0, 0);
        push_seg(CW,      0, 4'h2, 0, 0, 0);
    endtask

    task automatic push_write(input logic rs, input logic [7:0] dat);
        int wt;
        wt = CW;
`ifdef LCD_CLEAR_WAIT_EN
        if (!rs && (dat == 8'h01 || dat == 8'h02 || dat == 8'h03)) wt = CLRW;
`endif
        push_seg(SU, 0, dat[7:4], rs, 0, 1);
        push_seg(EC, 1, dat[7:4], rs, 0, 1);
        push_seg(NG, 0, dat[7:4], rs, 0, 1);
        push_seg(SU, 0, dat[3:0], rs, 0, 1);
        push_seg(EC, 1, dat[3:0], rs, 0, 1);
        push_seg(wt, 0, dat[3:0], rs, 0, 1);
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, advance model.
    task automatic step(input logic rst_i, input logic v, input logic rs_i,
                        input logic [7:0] dat, input string tag);
        obs_t obs;
        obs_t nxt;
        obs = '{e: lcd_e, d: lcd_d, rs: lcd_rs, rdy: wr_if.wr_ready, done: init_done};
        tests++;
        assert (obs === exp_cur) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed e/d/rs/rdy/done=%b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
                   tag, rel_cyc, obs.e, obs.d, obs.rs, obs.rdy, obs.done,
                   exp_cur.e, exp_cur.d, exp_cur.rs, exp_cur.rdy, exp_cur.done);
        end
        if (!mdl_rst && !seen_ready && obs.rdy === 1'b1) begin
            seen_ready = 1'b1;
            tests++;
            assert (rel_cyc == INIT_LEN) else begin
                fails++;
                $error("FAIL init_len observed %0d expected %0d", rel_cyc, INIT_LEN);
            end
        end

        reset          = rst_i;
        wr_if.wr_valid = v;
        wr_if.wr_rs    = rs_i;
        wr_if.wr_data  = dat;

        if (rst_i) begin
            exp_q.delete();
            mdl_rst    = 1'b1;
            seen_ready = 1'b0;
            nxt        = '0;
        end else if (mdl_rst) begin
            mdl_rst = 1'b0;
            push_init();
            rel_cyc = -1;
            nxt     = exp_q.pop_front();
        end else begin
            if (exp_cur.rdy && v) push_write(rs_i, dat);
            if (exp_q.size() > 0) nxt = exp_q.pop_front();
            else                  nxt = '{e: 0, d: 4'h0, rs: 0, rdy: 1, done: 1};
        end
        rel_cyc++;

        @(posedge clk);
        @(negedge clk);
        exp_cur = nxt;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, tag);
    endtask

    task automatic reset_and_init(input string tag);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, "in_reset");
        // Requests during init must be ignored; stop them before IDLE is reached.
        for (int i = 0; i < INIT_LEN + 6; i++) begin
            logic v;
            v = (i < INIT_LEN - 8) && ($urandom_range(0, 4) == 0);
            step(0, v, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), tag);
        end
    endtask

    initial begin
        int sent;
        reset          = 1'b1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_rs    = 1'b0;
        wr_if.wr_data  = 8'h00;
        mdl_rst        = 1'b1;
        seen_ready     = 1'b0;
        rel_cyc        = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_cur = '0;

        // Power-on init with ignored write requests.
        reset_and_init("init");

        // Data write 0x48, rs=1.
        step(0, 1, 1, 8'h48, "wr48");
        idle_cycles(28, "wr48");

        // Clear command 0x01, rs=0.
        step(0, 1, 0, 8'h01, "clear");
        idle_cycles(50, "clear");

        // Back-to-back 0x41 then 0x42 with wr_valid held.
        sent = 0;
        for (int i = 0; i < 60; i++) begin
            logic       v;
            logic       acc;
            logic [7:0] dat;
            v   = (sent < 2);
            dat = (sent == 0) ? 8'h41 : 8'h42;
            acc = v && exp_cur.rdy;
            step(0, v, 1, dat, "b2b");
            if (acc) sent++;
        end

        // Randomized traffic, biased toward clear/home command codes.
        for (int i = 0; i < 700; i++) begin
            logic       v;
            logic [7:0] dat;
            v   = ($urandom_range(0, 2) == 0);
            dat = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            step(0, v, 1'($urandom_range(0, 1)), dat, "rand");
        end

        // Drain to IDLE, start a write, then reset during the high-nibble pulse.
        for (int i = 0; i < 60 && !exp_cur.rdy; i++) step(0, 0, 0, 8'h00, "drain");
        step(0, 1, 1, 8'h48, "midrst");
        idle_cycles(2, "midrst");
        reset_and_init("reinit");
        step(0, 1, 1, 8'h5A, "post");
        idle_cycles(26, "post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
